// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM state encoding,
// IR field bit positions and counter sizing.
package fetch_pkg;

   localparam int DATA_W_C = 32;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 26;
   localparam int RS_MSB  = 25;
   localparam int RS_LSB  = 21;
   localparam int RT_MSB  = 20;
   localparam int RT_LSB  = 16;
   localparam int RD_MSB  = 15;
   localparam int RD_LSB  = 11;
   localparam int IMM_MSB = 15;
   localparam int IMM_LSB = 0;

   localparam int          CNT_W   = 16;
   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_HOLD = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Saturating performance counters for the fetch unit: accepted IR loads and
// cycles spent waiting on instruction memory.
module fetch_perf_cnt
   import fetch_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             instr_inc,
   input  logic             stall_inc,
   output logic [CNT_W-1:0] instr_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // Next-count logic; both counters stick at their maximum.
   always_comb begin
      instr_cnt_d = instr_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (instr_inc && (instr_cnt_q != CNT_MAX)) begin
         instr_cnt_d = instr_cnt_q + 16'd1;
      end else begin
         instr_cnt_d = instr_cnt_q;
      end
      if (stall_inc && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_cnt_q <= 16'd0;
         stall_cnt_q <= 16'd0;
      end else begin
         instr_cnt_q <= instr_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign instr_cnt = instr_cnt_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC, IR, single-entry fetch buffer and memory handshake FSM.
// Define FETCH_PERF_EN to build the instr_cnt/stall_cnt performance counters.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = DATA_W_C
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              InstRead,
   input  logic              ldIR,
   input  logic              incPC,
   input  logic              ldPC,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic [ADDR_W-1:0] pc,
   output logic [5:0]        opcode,
   output logic [4:0]        rs,
   output logic [4:0]        rt,
   output logic [4:0]        rd,
   output logic [15:0]       imm,
   output logic              fetch_stall,
   output logic              fetch_err,
   output logic [15:0]       instr_cnt,
   output logic [15:0]       stall_cnt
);

   fetch_state_e      state_q, state_d;
   logic              req_q, req_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] buf_q, buf_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] imm_ext_s;

   assign imm_ext_s = ADDR_W'(signed'(ir_q[IMM_MSB:IMM_LSB]));

   // Fetch handshake FSM next-state logic and sticky protocol-error detection.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      addr_d  = addr_q;
      buf_d   = buf_q;
      ir_d    = ir_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (InstRead) begin
               state_d = ST_REQ;
               req_d   = 1'b1;
               addr_d  = pc_q;
            end else begin
               state_d = ST_IDLE;
            end
            if (ldIR) begin
               err_d = 1'b1;
            end else begin
               err_d = err_q;
            end
         end
         ST_REQ: begin
            // Address stays frozen here even if PC moves underneath the read.
            if (imem_ack) begin
               state_d = ST_HOLD;
               req_d   = 1'b0;
               buf_d   = imem_rdata;
            end else begin
               state_d = ST_REQ;
            end
            if (InstRead || ldIR) begin
               err_d = 1'b1;
            end else begin
               err_d = err_q;
            end
         end
         ST_HOLD: begin
            if (ldIR) begin
               ir_d    = buf_q;
               state_d = ST_IDLE;
            end else begin
               ir_d = ir_q;
            end
            // A new request discards the buffer; if ldIR coincides it still loads first.
            if (InstRead) begin
               state_d = ST_REQ;
               req_d   = 1'b1;
               addr_d  = pc_q;
            end else begin
               req_d = req_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   // PC next value; a branch takes precedence over a sequential increment.
   always_comb begin
      pc_d = pc_q;
      if (ldPC) begin
         pc_d = pc_q + imm_ext_s;
      end else if (incPC) begin
         pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else begin
         pc_d = pc_q;
      end
   end

   // State, request, address, buffer, IR, PC and error registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         req_q   <= 1'b0;
         addr_q  <= '0;
         pc_q    <= '0;
         buf_q   <= '0;
         ir_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         pc_q    <= pc_d;
         buf_q   <= buf_d;
         ir_q    <= ir_d;
         err_q   <= err_d;
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = addr_q;
   assign pc          = pc_q;
   assign opcode      = ir_q[OPC_MSB:OPC_LSB];
   assign rs          = ir_q[RS_MSB:RS_LSB];
   assign rt          = ir_q[RT_MSB:RT_LSB];
   assign rd          = ir_q[RD_MSB:RD_LSB];
   assign imm         = ir_q[IMM_MSB:IMM_LSB];
   assign fetch_stall = (state_q == ST_REQ);
   assign fetch_err   = err_q;

`ifdef FETCH_PERF_EN
   fetch_perf_cnt u_perf (
      .clk       (clk),
      .rst_n     (rst_n),
      .instr_inc ((state_q == ST_HOLD) && ldIR),
      .stall_inc (state_q == ST_REQ),
      .instr_cnt (instr_cnt),
      .stall_cnt (stall_cnt)
   );
`else
   assign instr_cnt = 16'd0;
   assign stall_cnt = 16'd0;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the instruction word-address width (PC width).
REQ-002 Parameter DATA_W, default 32, SHALL set the instruction width; values other than 32 are unsupported.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 InstRead  in  1  SHALL be the one-cycle fetch start request from the control unit.
REQ-006 ldIR  in  1  SHALL load IR from the fetch buffer.
REQ-007 incPC  in  1  SHALL advance PC by one word.
REQ-008 ldPC  in  1  SHALL take a branch: PC <= PC + sext(imm).
REQ-009 imem_req  out  1  SHALL be the instruction memory read request, held until acknowledged.
REQ-010 imem_addr  out  ADDR_W  SHALL be the read address, equal to PC latched at request start.
REQ-011 imem_ack  in  1  SHALL be the memory acknowledge; imem_rdata is valid in the same cycle.
REQ-012 imem_rdata  in  DATA_W  SHALL be the returned instruction word.
REQ-013 pc  out  ADDR_W  SHALL be the current PC.
REQ-014 opcode/rs/rt/rd/imm  out  6/5/5/5/16  SHALL be IR[31:26]/[25:21]/[20:16]/[15:11]/[15:0].
REQ-015 fetch_stall  out  1  SHALL be high while a read is outstanding.
REQ-016 fetch_err  out  1  SHALL be the sticky protocol-error flag.
REQ-017 instr_cnt, stall_cnt  out  16 each  SHALL be the performance counters (see Configuration).

Function
REQ-018 SHALL implement states IDLE, REQ, HOLD; IDLE -InstRead-> REQ; REQ -imem_ack-> HOLD; HOLD -ldIR-> IDLE; HOLD -InstRead-> REQ (buffer discarded).
REQ-019 In REQ, imem_req SHALL be 1 and imem_addr constant; on imem_ack, imem_rdata is captured into the fetch buffer, next cycle state is HOLD.
REQ-020 Minimum latency SHALL be InstRead at cycle n -> imem_req at n+1 -> buffer valid at n+2 if imem_ack at n+1.
REQ-021 fetch_stall SHALL equal (state==REQ).
REQ-022 ldIR in HOLD SHALL copy the buffer into IR at the next edge; field outputs update combinationally from IR.
REQ-023 ldIR in IDLE or REQ SHALL leave IR unchanged and set fetch_err.
REQ-024 InstRead in REQ SHALL be ignored (request unchanged) and SHALL set fetch_err.
REQ-025 incPC SHALL perform PC <= PC+1 modulo 2^ADDR_W (FF..F wraps to 0).
REQ-026 ldPC SHALL perform PC <= PC + sext(imm) truncated to ADDR_W, using current IR imm.
REQ-027 incPC and ldPC in the same cycle: ldPC SHALL win.
REQ-028 PC updates during REQ SHALL NOT change imem_addr of the outstanding read.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, pc=0, IR=0, buffer invalid, imem_req=0, fetch_stall=0, fetch_err=0, counters=0.
REQ-030 Reset mid-REQ SHALL drop imem_req; a late imem_ack after reset release in IDLE SHALL be ignored.

Configuration
REQ-031 With FETCH_PERF_EN defined, instr_cnt SHALL count accepted ldIR and stall_cnt SHALL count cycles in REQ, both saturating at 16'hFFFF.
REQ-032 Without FETCH_PERF_EN, the ports SHALL remain present, tied to 0, with no counter registers.

Structure
REQ-033 Package fetch_pkg SHALL hold the state enum, IR field bit positions, and DATA_W=32 constant.
REQ-034 Counters SHALL live in sub-module fetch_perf_cnt, instantiated only under FETCH_PERF_EN.

Verification
REQ-035 Reset, InstRead, ack next cycle with rdata=32'h2022_1801, ldIR -> opcode=6'h08, rs=1, rt=2, rd=3, imm=16'h1801; imem_addr=0.
REQ-036 ack delayed 5 cycles -> fetch_stall high exactly 5 cycles, imem_addr stable, stall_cnt=5 (FETCH_PERF_EN).
REQ-037 pc=8'hFF, incPC -> pc=8'h00; pc=8'h10, imm=16'hFFFE, ldPC -> pc=8'h0E.
REQ-038 incPC and ldPC together with pc=8'h04, imm=3 -> pc=8'h07.
REQ-039 ldIR in IDLE, and InstRead during REQ -> IR unchanged, fetch_err=1 and held until reset.
REQ-040 rst_n low during REQ -> imem_req=0 immediately; late ack -> state IDLE, buffer invalid.
